// File: rtl/prog_clock_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_pkg
// Purpose  : Shared types and constants for the programmable clock divider.
//            Holds the per-channel state enum, the minimum legal divisor and
//            a constant-evaluable clog2 helper used for the channel index width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package prog_clock_divider_pkg;

  // Per-channel run state.
  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_RUN      = 2'd1,
    CH_STOPPING = 2'd2
  } ch_state_t;

  // Smallest divisor that still yields a clock: D=2 toggles every cycle.
  localparam int DIV_MIN = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Channel-select width; at least one bit even for a single channel.
  function automatic int ch_idx_w(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_if
// Purpose  : Divisor write port of the programmable clock divider.
// Signals  : div_wvalid  - write request (master -> slave)
//            div_wch     - target channel index (master -> slave)
//            div_wdata   - new divisor value (master -> slave)
//            div_wready  - write acceptance (slave -> master), combinational
// Modports : master (requester), slave (divider)
// Revision : 1.0 - initial release
// ============================================================================
interface prog_clock_divider_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  import prog_clock_divider_pkg::*;

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic             div_wvalid;
  logic [CH_W-1:0]  div_wch;
  logic [CNT_W-1:0] div_wdata;
  logic             div_wready;

  modport master (
    output div_wvalid,
    output div_wch,
    output div_wdata,
    input  div_wready
  );

  modport slave (
    input  div_wvalid,
    input  div_wch,
    input  div_wdata,
    output div_wready
  );

endinterface
`default_nettype wire

// File: rtl/prog_clock_divider_ch.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_ch
// Purpose  : One divider channel. Counts 0..D-1 while running, drives a
//            registered divided clock (low phase first) and a one-cycle tick
//            on each rising edge. New divisors are held in a shadow register
//            and only take effect on a period boundary (or at once when idle),
//            so a divisor change can never truncate a pulse.
// Macro    : PROG_CLOCK_DIVIDER_ODD_DUTY_EN - when defined, odd divisors get
//            a 50% duty cycle by ORing in a negedge-retimed copy of the
//            output; even divisors are unaffected.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            i_en       - run enable
//            i_wr       - accepted divisor write (already qualified by ready)
//            i_wdata    - divisor value to capture into the shadow register
//            o_pending  - shadow holds a divisor not yet loaded
//            o_clk_out  - divided clock
//            o_tick     - one-cycle pulse coincident with o_clk_out rising
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider_ch
  import prog_clock_divider_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_en,
  input  wire logic             i_wr,
  input  wire logic [CNT_W-1:0] i_wdata,
  output logic                  o_pending,
  output logic                  o_clk_out,
  output logic                  o_tick
);

  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DIV_MIN = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] c_DIV_RST = (DEFAULT_DIV < DIV_MIN) ? c_DIV_MIN
                                                                    : CNT_W'(DEFAULT_DIV);

  ch_state_t        r_state;
  ch_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] w_shadow_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_clk;
  logic             w_clk_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             w_last;
  logic [CNT_W-1:0] w_hi_start;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CH_IDLE;
      r_cnt     <= '0;
      r_div     <= c_DIV_RST;
      r_shadow  <= c_DIV_RST;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_clk     <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    // ">=" rather than "==" so a stray count can never run past the period.
    w_last        = (r_cnt >= (r_div - c_ONE));

    // A write is only accepted with nothing pending, so it can never collide
    // with the shadow load below (which requires pending).
    if (i_wr && !r_pending) begin
      w_shadow_nxt  = (i_wdata < c_DIV_MIN) ? c_DIV_MIN : i_wdata;
      w_pending_nxt = 1'b1;
    end

    unique case (r_state)
      CH_IDLE: begin
        w_cnt_nxt = '0;
        if (r_pending) begin
          w_div_nxt     = r_shadow;
          w_pending_nxt = 1'b0;
        end
        if (i_en) begin
          w_state_nxt = CH_RUN;
        end
      end

      CH_RUN, CH_STOPPING: begin
        // RUN and STOPPING count identically; they differ only in whether the
        // period boundary restarts the clock or parks the channel.
        if (w_last) begin
          w_cnt_nxt = '0;
          if (r_pending) begin
            w_div_nxt     = r_shadow;
            w_pending_nxt = 1'b0;
          end
          w_state_nxt = i_en ? CH_RUN : CH_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
          w_state_nxt = i_en ? CH_RUN : CH_STOPPING;
        end
      end

      default: begin
        w_state_nxt = CH_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // The clock register is computed from the *next* count and divisor, so
    // r_clk always reflects the count held in r_cnt during the same cycle.
    w_hi_start = w_div_nxt - (w_div_nxt >> 1);
    w_clk_nxt  = (w_state_nxt != CH_IDLE) && (w_cnt_nxt >= w_hi_start);
    w_tick_nxt = w_clk_nxt && !r_clk;
  end

  assign o_pending = r_pending;
  assign o_tick    = r_tick;

`ifdef PROG_CLOCK_DIVIDER_ODD_DUTY_EN
  // Half-cycle extension of the high phase for odd divisors. r_div is sampled
  // during the last high cycle, so a divisor change at the boundary cannot
  // stretch a pulse belonging to the new divisor.
  logic r_clk_neg;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_neg <= 1'b0;
    end else begin
      r_clk_neg <= r_clk & r_div[0];
    end
  end

  assign o_clk_out = r_clk | r_clk_neg;
`else
  assign o_clk_out = r_clk;
`endif

endmodule
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Purpose  : NUM_CH independent programmable clock dividers sharing one
//            divisor write port. This level only decodes the write to the
//            addressed channel and returns that channel's ready.
// Macro    : PROG_CLOCK_DIVIDER_ODD_DUTY_EN - 50% duty for odd divisors
//            (see prog_clock_divider_ch).
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            bus      - divisor write port (slave modport)
//            en       - per-channel run enable
//            clk_out  - per-channel divided clocks
//            tick     - per-channel rising-edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  prog_clock_divider_if.slave    bus,
  input  wire logic [NUM_CH-1:0] en,
  output logic      [NUM_CH-1:0] clk_out,
  output logic      [NUM_CH-1:0] tick
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;

  // Indices at or above NUM_CH match no channel, so they read as not ready
  // and the write goes nowhere.
  always_comb begin
    w_wr           = '0;
    bus.div_wready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.div_wch == CH_W'(i)) begin
        bus.div_wready = !w_pending[i];
        w_wr[i]        = bus.div_wvalid && !w_pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    prog_clock_divider_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en[g]),
      .i_wr      (w_wr[g]),
      .i_wdata   (bus.div_wdata),
      .o_pending (w_pending[g]),
      .o_clk_out (clk_out[g]),
      .o_tick    (tick[g])
    );
  end

endmodule
`default_nettype wire
